// File: rtl/clock_fnd_driver.sv
// Binary sec/min/hour to BCD (iterative subtract-by-10) and 6-digit multiplexed
// common-anode 7-segment drive.
//
// state  | meaning
// S_IDLE | waiting for {hour,min,sec} to differ from the last converted value
// S_DIV  | subtract 10 from every remainder still >= 10, count tens
// S_DONE | publish tens/remainders to o_bcd in one write
module clock_fnd_driver #(
  parameter int P_SEC_BIT  = 6,
  parameter int P_MIN_BIT  = 6,
  parameter int P_HOUR_BIT = 5,
  parameter int P_SCAN_CNT = 100000,
  parameter int P_SCAN_BIT = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [P_SEC_BIT-1:0]  i_sec,
  input  logic [P_MIN_BIT-1:0]  i_min,
  input  logic [P_HOUR_BIT-1:0] i_hour,
  input  logic                  i_blank,
  output logic                  o_busy,
  output logic [23:0]           o_bcd,
  output logic [5:0]            o_digit_n,
  output logic [7:0]            o_seg_n
);

  localparam int W = P_SEC_BIT + P_MIN_BIT + P_HOUR_BIT;
  localparam logic [P_SEC_BIT-1:0]  TEN_SEC  = P_SEC_BIT'(10);
  localparam logic [P_MIN_BIT-1:0]  TEN_MIN  = P_MIN_BIT'(10);
  localparam logic [P_HOUR_BIT-1:0] TEN_HOUR = P_HOUR_BIT'(10);
  localparam logic [P_SCAN_BIT-1:0] SCAN_LAST = P_SCAN_BIT'(P_SCAN_CNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t                state;
  logic [W-1:0]          r_last;
  logic [P_SEC_BIT-1:0]  rem_sec;
  logic [P_MIN_BIT-1:0]  rem_min;
  logic [P_HOUR_BIT-1:0] rem_hour;
  logic [3:0]            tens_sec, tens_min, tens_hour;
  logic [W-1:0]          time_now;
  logic                  sec_big, min_big, hour_big;

  assign time_now = {i_hour, i_min, i_sec};
  assign sec_big  = (rem_sec  >= TEN_SEC);
  assign min_big  = (rem_min  >= TEN_MIN);
  assign hour_big = (rem_hour >= TEN_HOUR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      r_last    <= '0;
      rem_sec   <= '0;
      rem_min   <= '0;
      rem_hour  <= '0;
      tens_sec  <= 4'd0;
      tens_min  <= 4'd0;
      tens_hour <= 4'd0;
      o_bcd     <= 24'h0;
      o_busy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (time_now != r_last) begin
            r_last    <= time_now;
            rem_sec   <= i_sec;
            rem_min   <= i_min;
            rem_hour  <= i_hour;
            tens_sec  <= 4'd0;
            tens_min  <= 4'd0;
            tens_hour <= 4'd0;
            state     <= S_DIV;
            o_busy    <= 1'b1;
          end
        end
        S_DIV: begin
          if (!sec_big && !min_big && !hour_big) begin
            state <= S_DONE;
          end else begin
            if (sec_big) begin
              rem_sec  <= rem_sec - TEN_SEC;
              tens_sec <= tens_sec + 4'd1;
            end
            if (min_big) begin
              rem_min  <= rem_min - TEN_MIN;
              tens_min <= tens_min + 4'd1;
            end
            if (hour_big) begin
              rem_hour  <= rem_hour - TEN_HOUR;
              tens_hour <= tens_hour + 4'd1;
            end
          end
        end
        S_DONE: begin
          o_bcd  <= {tens_hour, 4'(rem_hour), tens_min, 4'(rem_min),
                     tens_sec, 4'(rem_sec)};
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  logic [P_SCAN_BIT-1:0] scan_cnt;
  logic [2:0]            digit_idx;
  logic [3:0]            nibble;
  logic [6:0]            seg_code;
  logic                  dp_n;

  always_comb begin
    nibble = o_bcd[3:0];
    case (digit_idx)
      3'd1:    nibble = o_bcd[7:4];
      3'd2:    nibble = o_bcd[11:8];
      3'd3:    nibble = o_bcd[15:12];
      3'd4:    nibble = o_bcd[19:16];
      3'd5:    nibble = o_bcd[23:20];
      default: nibble = o_bcd[3:0];
    endcase
  end

  // {g,f,e,d,c,b,a}, active low; anything above 9 stays dark
  always_comb begin
    seg_code = 7'h7F;
    case (nibble)
      4'd0: seg_code = 7'h40;
      4'd1: seg_code = 7'h79;
      4'd2: seg_code = 7'h24;
      4'd3: seg_code = 7'h30;
      4'd4: seg_code = 7'h19;
      4'd5: seg_code = 7'h12;
      4'd6: seg_code = 7'h02;
      4'd7: seg_code = 7'h78;
      4'd8: seg_code = 7'h00;
      4'd9: seg_code = 7'h10;
      default: seg_code = 7'h7F;
    endcase
  end

  assign dp_n = !((digit_idx == 3'd2) || (digit_idx == 3'd4));

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt  <= '0;
      digit_idx <= 3'd0;
      o_digit_n <= 6'h3F;
      o_seg_n   <= 8'hFF;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt  <= '0;
        digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      o_digit_n <= i_blank ? 6'h3F : ~(6'd1 << digit_idx);
      o_seg_n   <= {dp_n, seg_code};
    end
  end

endmodule
